// File: rtl/bpm_test_link_checker.sv
// Receive-side checker for the BPM test link: validates framing, sequence and
// payload pattern of Aurora RX packets and keeps counters and sticky error flags.
module bpm_test_link_checker #(
  parameter int PAYLOAD_WORDS = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     auroraUserClk,
  input  logic                     auroraReset,
  input  logic                     auroraChannelUp,
  input  logic                     clearStatus,
  input  logic [31:0]              BPM_TEST_AXI_STREAM_RX_tdata,
  input  logic                     BPM_TEST_AXI_STREAM_RX_tvalid,
  input  logic                     BPM_TEST_AXI_STREAM_RX_tlast,
  output logic [15:0]              pktCount,
  output logic [ERR_CNT_WIDTH-1:0] errCount,
  output logic [3:0]               errFlags,
  output logic [4:0]               lastBpmIndex,
  output logic                     seqLocked,
  output logic                     pktStrobe
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, RESYNC} state_t;

  localparam logic [7:0] MAGIC  = 8'hA5;
  localparam logic [7:0] LEN    = 8'(PAYLOAD_WORDS);
  localparam logic [7:0] LAST_K = 8'(PAYLOAD_WORDS - 1);

  state_t                   state_q;
  logic [7:0]               k_q, seq_q, expSeq_q;
  logic [4:0]               bpm_q, lastBpm_q;
  logic                     seqLocked_q, pktErr_q, pktStrobe_q;
  logic [15:0]              pktCount_q, pktCount_d, pktBase;
  logic [ERR_CNT_WIDTH-1:0] errCount_q, errCount_d, errBase;
  logic [3:0]               errFlags_q, errFlags_d;

  logic        beat, magicOk, endGood, countErr;
  logic [3:0]  newErr;
  logic [7:0]  rxSeq;
  logic [31:0] expData;

  assign beat    = auroraChannelUp & BPM_TEST_AXI_STREAM_RX_tvalid;
  assign magicOk = (BPM_TEST_AXI_STREAM_RX_tdata[31:24] == MAGIC);
  assign rxSeq   = BPM_TEST_AXI_STREAM_RX_tdata[23:16];
  assign expData = {seq_q, k_q, ~seq_q, ~k_q};

  // Error bits: {dataErr, lenErr, seqErr, magicErr}
  always_comb begin
    newErr = '0;
    if (beat) begin
      case (state_q)
        HEADER: begin
          if (!magicOk)
            newErr[0] = 1'b1;
          else if (BPM_TEST_AXI_STREAM_RX_tlast || (BPM_TEST_AXI_STREAM_RX_tdata[7:0] != LEN))
            newErr[2] = 1'b1;
          else if (seqLocked_q && (rxSeq != expSeq_q))
            newErr[1] = 1'b1;
        end
        PAYLOAD: begin
          newErr[3] = (BPM_TEST_AXI_STREAM_RX_tdata != expData);
          newErr[2] = BPM_TEST_AXI_STREAM_RX_tlast ? (k_q != LAST_K) : (k_q == LAST_K);
        end
        default: ;
      endcase
    end
    endGood  = beat && (state_q == PAYLOAD) && BPM_TEST_AXI_STREAM_RX_tlast &&
               (k_q == LAST_K) && !pktErr_q && (newErr == 4'b0000);
    // A packet contributes to errCount only on its first erroring beat
    countErr = (|newErr) && ((state_q == HEADER) || !pktErr_q);

    // Clear takes effect first, then this cycle's event is applied on top
    pktBase    = clearStatus ? '0 : pktCount_q;
    errBase    = clearStatus ? '0 : errCount_q;
    pktCount_d = pktBase + 16'(endGood);
    errCount_d = (countErr && (errBase != '1)) ? errBase + ERR_CNT_WIDTH'(1) : errBase;
    errFlags_d = (clearStatus ? 4'b0000 : errFlags_q) | newErr;
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      expSeq_q    <= '0;
      seqLocked_q <= 1'b0;
      pktErr_q    <= 1'b0;
      pktStrobe_q <= 1'b0;
      pktCount_q  <= '0;
      errCount_q  <= '0;
      errFlags_q  <= '0;
      lastBpm_q   <= '0;
    end else begin
      pktCount_q  <= pktCount_d;
      errCount_q  <= errCount_d;
      errFlags_q  <= errFlags_d;
      pktStrobe_q <= endGood;
      if (endGood) lastBpm_q <= bpm_q;

      if (!auroraChannelUp) begin
        state_q     <= IDLE;
        seqLocked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= HEADER;
          HEADER: if (BPM_TEST_AXI_STREAM_RX_tvalid) begin
            if (!magicOk)
              state_q <= BPM_TEST_AXI_STREAM_RX_tlast ? HEADER : RESYNC;
            else if (BPM_TEST_AXI_STREAM_RX_tlast)
              state_q <= HEADER;
            else if (BPM_TEST_AXI_STREAM_RX_tdata[7:0] != LEN)
              state_q <= RESYNC;
            else begin
              state_q     <= PAYLOAD;
              k_q         <= '0;
              seq_q       <= rxSeq;
              bpm_q       <= BPM_TEST_AXI_STREAM_RX_tdata[12:8];
              expSeq_q    <= rxSeq + 8'd1;
              seqLocked_q <= 1'b1;
              pktErr_q    <= newErr[1];
            end
          end
          PAYLOAD: if (BPM_TEST_AXI_STREAM_RX_tvalid) begin
            pktErr_q <= pktErr_q | (|newErr);
            k_q      <= k_q + 8'd1;
            if (BPM_TEST_AXI_STREAM_RX_tlast)
              state_q <= HEADER;
            else if (k_q == LAST_K)
              state_q <= RESYNC;
          end
          RESYNC: if (BPM_TEST_AXI_STREAM_RX_tvalid && BPM_TEST_AXI_STREAM_RX_tlast)
            state_q <= HEADER;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pktCount     = pktCount_q;
  assign errCount     = errCount_q;
  assign errFlags     = errFlags_q;
  assign lastBpmIndex = lastBpm_q;
  assign seqLocked    = seqLocked_q;
  assign pktStrobe    = pktStrobe_q;

endmodule

// File: tb/tb_bpm_test_link_checker.sv
// Scoreboard bench for bpm_test_link_checker: directed packets push expected
// events; a negedge monitor pops them when the DUT strobes or its status changes.
module tb_bpm_test_link_checker;
  localparam int PW  = 8;
  localparam int ECW = 3;

  logic            clk = 1'b0;
  logic            rst, chUp, clr, tvalid, tlast;
  logic [31:0]     tdata;
  logic [15:0]     pktCount;
  logic [ECW-1:0]  errCount;
  logic [3:0]      errFlags;
  logic [4:0]      lastBpmIndex;
  logic            seqLocked, pktStrobe;

  always #5 clk = ~clk;

  bpm_test_link_checker #(.PAYLOAD_WORDS(PW), .ERR_CNT_WIDTH(ECW)) dut (
    .auroraUserClk                (clk),
    .auroraReset                  (rst),
    .auroraChannelUp              (chUp),
    .clearStatus                  (clr),
    .BPM_TEST_AXI_STREAM_RX_tdata (tdata),
    .BPM_TEST_AXI_STREAM_RX_tvalid(tvalid),
    .BPM_TEST_AXI_STREAM_RX_tlast (tlast),
    .pktCount                     (pktCount),
    .errCount                     (errCount),
    .errFlags                     (errFlags),
    .lastBpmIndex                 (lastBpmIndex),
    .seqLocked                    (seqLocked),
    .pktStrobe                    (pktStrobe)
  );

  typedef struct packed {logic [15:0] pc; logic [4:0] bpm;} pkt_t;
  typedef struct packed {logic [ECW-1:0] ec; logic [3:0] ef;} err_t;
  pkt_t pkt_q[$];
  err_t err_q[$];

  int n_chk = 0;
  int n_pass = 0;
  bit gaps = 1'b0;
  logic [15:0]    m_pc = '0;
  logic [ECW-1:0] m_ec = '0;
  logic [3:0]     m_ef = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Counter model: clear first, then the error (if any) of the same cycle
  task automatic exp_update(input bit c, input logic [3:0] bits);
    err_t old;
    old = '{m_ec, m_ef};
    if (c) begin m_pc = '0; m_ec = '0; m_ef = '0; end
    if (bits != 4'b0000) begin
      if (m_ec != '1) m_ec = m_ec + 1'b1;
      m_ef = m_ef | bits;
    end
    if ({m_ec, m_ef} != old) err_q.push_back('{m_ec, m_ef});
  endtask

  task automatic exp_good(input logic [4:0] bpm);
    m_pc = m_pc + 16'd1;
    pkt_q.push_back('{m_pc, bpm});
  endtask

  // Monitor
  logic           mon_en = 1'b0;
  logic [ECW-1:0] prev_ec = '0;
  logic [3:0]     prev_ef = '0;
  pkt_t           mp;
  err_t           me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (pktStrobe) begin
        if (pkt_q.size() == 0) chk("pkt_strobe_expected", {31'b0, pktStrobe}, 32'd0);
        else begin
          mp = pkt_q.pop_front();
          chk("pkt_count", {16'b0, pktCount}, {16'b0, mp.pc});
          chk("pkt_bpm", {27'b0, lastBpmIndex}, {27'b0, mp.bpm});
        end
      end
      if (errCount != prev_ec || errFlags != prev_ef) begin
        if (err_q.size() == 0) chk("err_change_expected", {25'b0, errCount, errFlags}, {25'b0, prev_ec, prev_ef});
        else begin
          me = err_q.pop_front();
          chk("err_count", {29'b0, errCount}, {29'b0, me.ec});
          chk("err_flags", {28'b0, errFlags}, {28'b0, me.ef});
        end
        prev_ec = errCount;
        prev_ef = errFlags;
      end
    end
  end

  function automatic logic [31:0] hdr(input logic [7:0] mg, input logic [7:0] sq,
                                      input logic [4:0] b, input logic [7:0] ln);
    return {mg, sq, 3'b000, b, ln};
  endfunction

  function automatic logic [31:0] pay(input logic [7:0] sq, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {sq, kk, ~sq, ~kk};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit c);
    if (gaps) idle(int'($urandom_range(0, 1)));
    tdata = d; tlast = last; tvalid = 1'b1; clr = c;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b1; tdata = 32'hDEAD_BEEF; clr = 1'b0;
  endtask

  task automatic good_pkt(input logic [7:0] sq, input logic [4:0] bpm, input bit clr_last);
    send_beat(hdr(8'hA5, sq, bpm, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < PW; k++) begin
      if (k == PW - 1) begin
        if (clr_last) exp_update(1'b1, 4'b0000);
        exp_good(bpm);
      end
      send_beat(pay(sq, k), k == PW - 1, (k == PW - 1) && clr_last);
    end
  endtask

  task automatic do_clear();
    exp_update(1'b1, 4'b0000);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [15:0] pc, input logic [ECW-1:0] ec,
                              input logic [3:0] ef, input logic lk, input logic [4:0] bpm);
    idle(2);
    chk({tag, "_pktCount"}, {16'b0, pktCount}, {16'b0, pc});
    chk({tag, "_errCount"}, {29'b0, errCount}, {29'b0, ec});
    chk({tag, "_errFlags"}, {28'b0, errFlags}, {28'b0, ef});
    chk({tag, "_seqLocked"}, {31'b0, seqLocked}, {31'b0, lk});
    chk({tag, "_lastBpm"}, {27'b0, lastBpmIndex}, {27'b0, bpm});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; chUp = 1'b1; clr = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pktCount", {16'b0, pktCount}, 32'd0);
    chk("rst_errCount", {29'b0, errCount}, 32'd0);
    chk("rst_errFlags", {28'b0, errFlags}, 32'd0);
    chk("rst_lastBpm", {27'b0, lastBpmIndex}, 32'd0);
    chk("rst_seqLocked", {31'b0, seqLocked}, 32'd0);
    chk("rst_pktStrobe", {31'b0, pktStrobe}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(3);

    // Three good packets
    good_pkt(8'd5, 5'd1, 1'b0);
    good_pkt(8'd6, 5'd1, 1'b0);
    good_pkt(8'd7, 5'd1, 1'b0);
    check_status("good3", 16'd3, 3'd0, 4'b0000, 1'b1, 5'd1);

    // Channel drops mid-packet
    send_beat(hdr(8'hA5, 8'd8, 5'd1, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_beat(pay(8'd8, k), 1'b0, 1'b0);
    chUp = 1'b0;
    check_status("chdrop", 16'd3, 3'd0, 4'b0000, 1'b0, 5'd1);
    chUp = 1'b1;
    idle(2);

    // Sequence gap
    do_clear();
    good_pkt(8'd10, 5'd2, 1'b0);
    exp_update(1'b0, 4'b0010);
    send_beat(hdr(8'hA5, 8'd12, 5'd2, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < PW; k++) send_beat(pay(8'd12, k), k == PW - 1, 1'b0);
    good_pkt(8'd13, 5'd2, 1'b0);
    check_status("seqerr", 16'd2, 3'd1, 4'b0010, 1'b1, 5'd2);

    // Payload corruption
    do_clear();
    send_beat(hdr(8'hA5, 8'd14, 5'd3, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < PW; k++) begin
      if (k == 3) exp_update(1'b0, 4'b1000);
      send_beat((k == 3) ? (pay(8'd14, k) ^ 32'h1) : pay(8'd14, k), k == PW - 1, 1'b0);
    end
    good_pkt(8'd15, 5'd3, 1'b0);
    check_status("dataerr", 16'd1, 3'd1, 4'b1000, 1'b1, 5'd3);

    // Early tlast on payload beat 5
    do_clear();
    send_beat(hdr(8'hA5, 8'd16, 5'd4, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) exp_update(1'b0, 4'b0100);
      send_beat(pay(8'd16, k), k == 5, 1'b0);
    end
    good_pkt(8'd17, 5'd4, 1'b0);
    check_status("early", 16'd1, 3'd1, 4'b0100, 1'b1, 5'd4);

    // Missing tlast plus four extra beats
    do_clear();
    send_beat(hdr(8'hA5, 8'd18, 5'd5, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < PW; k++) begin
      if (k == PW - 1) exp_update(1'b0, 4'b0100);
      send_beat(pay(8'd18, k), 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) send_beat(hdr(8'hA5, 8'd99, 5'd9, 8'(PW)), i == 3, 1'b0);
    good_pkt(8'd19, 5'd5, 1'b0);
    check_status("late", 16'd1, 3'd1, 4'b0100, 1'b1, 5'd5);

    // Bad magic; rest of the packet discarded
    do_clear();
    exp_update(1'b0, 4'b0001);
    send_beat(hdr(8'h5A, 8'd20, 5'd6, 8'(PW)), 1'b0, 1'b0);
    for (int k = 0; k < PW; k++) send_beat(pay(8'd20, k), k == PW - 1, 1'b0);
    good_pkt(8'd20, 5'd6, 1'b0);
    check_status("magic", 16'd1, 3'd1, 4'b0001, 1'b1, 5'd6);

    // Random valid gaps
    do_clear();
    gaps = 1'b1;
    good_pkt(8'd21, 5'd7, 1'b0);
    good_pkt(8'd22, 5'd7, 1'b0);
    good_pkt(8'd23, 5'd7, 1'b0);
    gaps = 1'b0;
    check_status("gaps", 16'd3, 3'd0, 4'b0000, 1'b1, 5'd7);

    // clearStatus coinciding with an error, then with a good packet end
    exp_update(1'b0, 4'b0001);
    send_beat(hdr(8'h5A, 8'd0, 5'd0, 8'(PW)), 1'b1, 1'b0);
    exp_update(1'b0, 4'b0100);
    send_beat(hdr(8'hA5, 8'd0, 5'd0, 8'(PW)), 1'b1, 1'b0);
    exp_update(1'b1, 4'b0001);
    send_beat(hdr(8'h5A, 8'd0, 5'd0, 8'(PW)), 1'b1, 1'b1);
    check_status("clrerr", 16'd0, 3'd1, 4'b0001, 1'b1, 5'd7);
    good_pkt(8'd24, 5'd8, 1'b0);
    good_pkt(8'd25, 5'd9, 1'b1);
    check_status("clrgood", 16'd1, 3'd0, 4'b0000, 1'b1, 5'd9);

    // errCount saturation
    for (int i = 0; i < 9; i++) begin
      exp_update(1'b0, 4'b0001);
      send_beat(hdr(8'h5A, 8'd0, 5'd0, 8'(PW)), 1'b1, 1'b0);
    end
    check_status("sat", 16'd1, 3'd7, 4'b0001, 1'b1, 5'd9);

    idle(5);
    chk("pkt_queue_drained", 32'(pkt_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
